// File: rtl/divider_4bit_seq_pkg.sv
// rtl/divider_4bit_seq_pkg.sv - shared constants and state encoding for the 4-bit sequential divider
package divider_4bit_seq_pkg;

  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_4bit_seq_if.sv
// rtl/divider_4bit_seq_if.sv - start/busy/done handshake and operand/result bundle of the divider
interface divider_4bit_seq_if;
  import divider_4bit_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, div_by_zero
  );

endinterface

// File: rtl/add_sub.sv
// rtl/add_sub.sv - one-bit ripple adder/subtractor cell; sel=1 inverts b for subtraction
module add_sub (
  input  logic a,
  input  logic b,
  input  logic sel,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic bx;

  assign bx   = b ^ sel;
  assign s    = a ^ bx ^ cin;
  assign cout = (a & bx) | (a & cin) | (bx & cin);

endmodule

// File: rtl/divider_4bit_seq_trial_sub.sv
// rtl/divider_4bit_seq_trial_sub.sv - 5-bit trial subtractor built from a ripple chain of add_sub cells
module trial_sub_5bit
  import divider_4bit_seq_pkg::*;
(
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] diff,
  output logic           no_borrow
);

  logic [WIDTH+1:0] carry;

  // Two's-complement subtraction: the chain's carry-in supplies the +1.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    add_sub u_cell (
      .a    (minuend[i]),
      .b    (subtrahend[i]),
      .sel  (1'b1),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign no_borrow = carry[WIDTH+1];

endmodule

// File: rtl/divider_4bit_seq.sv
// rtl/divider_4bit_seq.sv - sequential 4-bit unsigned restoring divider, one quotient bit per clock
module divider_4bit_seq
  import divider_4bit_seq_pkg::*;
(
  input logic               clk,
  input logic               nrst,
  divider_4bit_seq_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [1:0]       step;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz_reg;
  logic             busy;
  logic             done;

  logic [WIDTH:0]   trial_in;
  logic [WIDTH:0]   trial_diff;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] dividend_next;
  logic             no_borrow;
  logic             unused_rem_msb;

  // Shifted partial remainder; the quotient grows in place at the dividend LSB.
  assign trial_in      = {rem[WIDTH-1:0], dividend[WIDTH-1]};
  assign rem_next      = no_borrow ? trial_diff : trial_in;
  assign dividend_next = {dividend[WIDTH-2:0], no_borrow};
  assign unused_rem_msb = rem[WIDTH];

  trial_sub_5bit u_trial (
    .minuend    (trial_in),
    .subtrahend ({1'b0, divisor}),
    .diff       (trial_diff),
    .no_borrow  (no_borrow)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.B == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (step == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      step     <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.B == '0) begin
              q_reg   <= DIV0_QUOTIENT;
              r_reg   <= bus.A;
              dbz_reg <= 1'b1;
            end else begin
              dividend <= bus.A;
              divisor  <= bus.B;
              rem      <= '0;
              step     <= '0;
            end
          end
        end
        CALC: begin
          rem      <= rem_next;
          dividend <= dividend_next;
          step     <= step + 2'd1;
          // Final step publishes straight from the step logic so Q/R land on the same edge.
          if (step == 2'd3) begin
            q_reg   <= dividend_next;
            r_reg   <= rem_next[WIDTH-1:0];
            dbz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q           = q_reg;
  assign bus.R           = r_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb/tb_divider_4bit_seq.sv - self-checking bench for divider_4bit_seq with a result scoreboard
module tb_divider_4bit_seq;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  divider_4bit_seq_if bus ();

  divider_4bit_seq dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.lat = 5;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; launches one operation, optionally injects a start pulse
  // at cycle 'inject' (must be ignored), waits for done and compares with the scoreboard.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int inject, input string tag);
    exp_t e;
    int   n;
    bit   got;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    sb.push_back(model(a, b));
    n   = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      bus.start = (inject != 0 && n == inject);
      bus.A     = (bus.start) ? 4'd1 : 4'($urandom);
      bus.B     = (bus.start) ? 4'd1 : 4'($urandom);
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check({tag, " latency"}, 32'(n), 32'(e.lat));
    check({tag, " Q"}, 32'(bus.Q), 32'(e.q));
    check({tag, " R"}, 32'(bus.R), 32'(e.r));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({tag, " busy fall"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = 4'd0;
    bus.B     = 4'd0;
    repeat (2) @(negedge clk);
    check("reset Q", 32'(bus.Q), 32'd0);
    check("reset R", 32'(bus.R), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    run_op(4'd13, 4'd3, 0, "13/3");
    run_op(4'd15, 4'd1, 0, "15/1");
    run_op(4'd5, 4'd7, 0, "5/7");
    run_op(4'd0, 4'd9, 0, "0/9");
    run_op(4'd9, 4'd0, 0, "9/0");
    run_op(4'd8, 4'd2, 0, "8/2");

    run_op(4'd12, 4'd5, 2, "12/5 ignored start");
    repeat (3) @(negedge clk);
    check("hold Q", 32'(bus.Q), 32'd2);
    check("hold R", 32'(bus.R), 32'd2);
    check("hold busy", 32'(bus.busy), 32'd0);

    // Abort 14/3 mid-calculation with an asynchronous reset.
    bus.start = 1'b1;
    bus.A     = 4'd14;
    bus.B     = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort Q", 32'(bus.Q), 32'd0);
    check("abort R", 32'(bus.R), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_op(4'd14, 4'd3, 0, "14/3 after abort");

    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        run_op(4'(a), 4'(b), 0, $sformatf("%0d/%0d", a, b));
      end
    end

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
